// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence detector front end and its benches.
// Holds the default word width, the word type and the serializer's debug state encoding.
package seq_pkg;

    localparam int SEQ_WORD_W = 32;
    // Bit-counter width for a default-width word (counts 0..SEQ_WORD_W).
    localparam int SEQ_CNT_W  = $clog2(SEQ_WORD_W + 1);

    typedef logic [SEQ_WORD_W-1:0] seq_word_t;

    // {shifter busy, hold full}
    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'b00,
        SEQ_PENDING   = 2'b01,
        SEQ_SHIFT     = 2'b10,
        SEQ_SHIFT_BUF = 2'b11
    } seq_state_t;

endpackage

// File: rtl/seq_hold_reg.sv
// One-entry valid/ready holding buffer in front of the serializer's shifter.
// Handshake: a word moves on an edge where in_valid && in_ready; in_ready never depends on in_valid.
module seq_hold_reg
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             pop,
    output logic             in_ready,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    assign in_ready = !hold_full && !flush;

    // Accept and pop are mutually exclusive: accept needs an empty buffer, pop a full one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (flush) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (in_valid && in_ready) begin
            hold      <= in_data;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: buffers one word and streams it one bit per clock on seq.
// Define SEQ_SER_LSB_FIRST_EN to emit bit 0 first; default build emits the MSB first.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             seq,
    output logic             seq_valid,
    output logic             word_done,
    output seq_state_t       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic [CNT_W-1:0] cnt;
    logic             hold_full;
    logic             load;
    logic             pop;

    // Reloading during the last bit (cnt == 1) is what makes back-to-back words gapless.
    assign load = hold_full && (cnt <= CNT_ONE);
    assign pop  = load && !flush;

    seq_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (flush),
        .pop       (pop),
        .in_ready  (in_ready),
        .hold      (hold),
        .hold_full (hold_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (flush) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= hold;
            cnt <= CNT_FULL;
        end else if (cnt > CNT_ONE) begin
`ifdef SEQ_SER_LSB_FIRST_EN
            sh  <= sh >> 1;
`else
            sh  <= sh << 1;
`endif
            cnt <= cnt - CNT_ONE;
        end else if (cnt == CNT_ONE) begin
            cnt <= '0;
        end
    end

    always_comb begin
        seq_valid = (cnt != '0);
        word_done = (cnt == CNT_ONE);
`ifdef SEQ_SER_LSB_FIRST_EN
        seq       = seq_valid && sh[0];
`else
        seq       = seq_valid && sh[WIDTH-1];
`endif
    end

    always_comb begin
        dbg_state = SEQ_IDLE;
        case ({seq_valid, hold_full})
            2'b00:   dbg_state = SEQ_IDLE;
            2'b01:   dbg_state = SEQ_PENDING;
            2'b10:   dbg_state = SEQ_SHIFT;
            default: dbg_state = SEQ_SHIFT_BUF;
        endcase
    end

endmodule
